// File: rtl/fifo_rr_arbiter.sv
// Round-robin consumer for a bank of FIFOs: pops one word per cycle from eligible FIFOs,
// forwards it with its source tag two cycles after the read strobe, and keeps per-FIFO counters.
module fifo_rr_arbiter #(
    parameter int data_width = 10,
    parameter int num_fifos  = 4,
    parameter int cnt_width  = 8,
    localparam int id_width  = $clog2(num_fifos)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [num_fifos*data_width-1:0] data_in,
    input  logic [num_fifos-1:0]            empty_fifo,
    input  logic [num_fifos-1:0]            almost_empty_fifo,
    input  logic [num_fifos-1:0]            error_fifo,
    input  logic                            almost_full_out,
    output logic [num_fifos-1:0]            rd_enable,
    output logic [data_width-1:0]           data_out,
    output logic                            valid_out,
    output logic [id_width-1:0]             src_id,
    output logic [num_fifos*cnt_width-1:0]  count_out,
    output logic                            error_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    state_t                                 state_r;
    state_t                                 state_next_s;
    logic [num_fifos-1:0]                   eligible_s;
    logic                                   any_eligible_s;
    logic [id_width-1:0]                    last_grant_r;
    logic [id_width-1:0]                    grant_id_s;
    logic [id_width-1:0]                    scan_id_s;
    logic                                   found_s;
    logic [num_fifos-1:0]                   rd_next_s;
    logic                                   rd_valid_r;
    logic [id_width-1:0]                    rd_id_r;
    logic [num_fifos-1:0][cnt_width-1:0]    cnt_r;

    function automatic logic [id_width-1:0] onehot_to_id(input logic [num_fifos-1:0] oh);
        logic [id_width-1:0] id;
        id = '0;
        for (int k = 0; k < num_fifos; k++) begin
            id = id | (oh[k] ? id_width'(k) : {id_width{1'b0}});
        end
        return id;
    endfunction

    // A FIFO whose last word is being popped right now must not be granted again.
    assign eligible_s     = ~empty_fifo & ~(rd_enable & almost_empty_fifo);
    assign any_eligible_s = |eligible_s;
    assign count_out      = cnt_r;

    // Round-robin search starting just after the previous grant.
    always_comb begin
        grant_id_s = last_grant_r;
        found_s    = 1'b0;
        scan_id_s  = '0;
        for (int k = 1; k <= num_fifos; k++) begin
            scan_id_s = last_grant_r + id_width'(k);
            if (!found_s && eligible_s[scan_id_s]) begin
                found_s    = 1'b1;
                grant_id_s = scan_id_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; throttle takes priority over continuing to read.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_eligible_s && !almost_full_out) state_next_s = ACTIVE;
                else                                    state_next_s = IDLE;
            end
            ACTIVE: begin
                if (almost_full_out)      state_next_s = PAUSE;
                else if (!any_eligible_s) state_next_s = IDLE;
                else                      state_next_s = ACTIVE;
            end
            PAUSE: begin
                if (!almost_full_out) state_next_s = IDLE;
                else                  state_next_s = PAUSE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Read strobe for the coming cycle: one-hot on the grant while ACTIVE.
    always_comb begin
        rd_next_s = '0;
        if (state_next_s == ACTIVE) begin
            rd_next_s[grant_id_s] = 1'b1;
        end else begin
            rd_next_s = '0;
        end
    end

    // Registered read strobe and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_enable    <= '0;
            last_grant_r <= id_width'(num_fifos - 1);
        end else begin
            rd_enable <= rd_next_s;
            if (state_next_s == ACTIVE) begin
                last_grant_r <= grant_id_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Two-stage return path: remember which FIFO was read, then capture its word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_id_r    <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            src_id     <= '0;
        end else begin
            rd_valid_r <= |rd_enable;
            rd_id_r    <= onehot_to_id(rd_enable);
            valid_out  <= rd_valid_r;
            if (rd_valid_r) begin
                data_out <= data_in[rd_id_r*data_width +: data_width];
                src_id   <= rd_id_r;
            end else begin
                data_out <= data_out;
                src_id   <= src_id;
            end
        end
    end

    // Per-FIFO forwarded-word counters, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < num_fifos; i++) begin
                if (valid_out && (src_id == id_width'(i))) begin
                    cnt_r[i] <= cnt_r[i] + cnt_width'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_out <= 1'b0;
        end else begin
            error_out <= error_out | (|error_fifo);
        end
    end

endmodule
